wb_arbiter: RTL and testbench

- Sequences the shared Wishbone-style system bus between two OpenMIPS masters: instruction fetch (ibus) and load/store (dbus).
- Grants one master at a time, round-robin on contention.
- Decodes the granted address into the one-hot 16-bit slave select consumed by the bus fabric.
- Drives the bus for one transfer, bounds the wait with a timeout, and returns registered data and ack/err to the granted master.

---
 rtl/wb_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master (ibus/dbus) arbiter for the shared Wishbone-style bus.
// It arbitrates round-robin on contention and decodes addr[31:28] into a
// one-hot slave select. It runs one bounded transfer and then returns a
// registered one-cycle ack/err with read data to the granted master.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   i_req_i, i_addr_i    ibus request / address (read-only master)
//   i_data_o, i_ack_o,   ibus read data, completion pulse, error pulse
//   i_err_o
//   d_req_i, d_we_i,     dbus request / write enable / address / write data
//   d_addr_i, d_data_i
//   d_data_o, d_ack_o,   dbus read data, completion pulse, error pulse
//   d_err_o
//   b_addr_o, b_data_o,  bus fabric address / write data / write enable
//   b_we_o, b_select_o   and one-hot slave select (0 = no cycle)
//   b_data_i, b_ack_i    bus fabric read data / slave ack
//   grant_o              current/last owner: 0 = ibus, 1 = dbus
module wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned NUM_SLAVES     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_data_o,
  output logic        i_ack_o,
  output logic        i_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] b_addr_o,
  output logic [31:0] b_data_o,
  output logic        b_we_o,
  output logic [15:0] b_select_o,
  input  logic [31:0] b_data_i,
  input  logic        b_ack_i,
  output logic        grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q;
  logic        last_q;      // last granted master, 1 = dbus
  logic [7:0]  timer_q;
  logic [31:0] b_addr_q;
  logic [31:0] b_data_q;
  logic        b_we_q;
  logic [15:0] b_sel_q;
  logic [31:0] i_data_q;
  logic        i_ack_q;
  logic        i_err_q;
  logic [31:0] d_data_q;
  logic        d_ack_q;
  logic        d_err_q;

  logic        pick_d_d;    // 1 = grant dbus this cycle
  logic        any_req_d;
  logic [31:0] req_addr_d;
  logic [3:0]  idx_d;
  logic        dec_ok_d;
  logic [15:0] sel_dec_d;
  logic        timeout_d;

  always_comb begin
    any_req_d  = i_req_i | d_req_i;
    // dbus wins when alone, or on a tie when ibus was granted last
    pick_d_d   = d_req_i & (~i_req_i | ~last_q);
    req_addr_d = pick_d_d ? d_addr_i : i_addr_i;
    idx_d      = req_addr_d[31:28];
    dec_ok_d   = ({28'd0, idx_d} < 32'(NUM_SLAVES));
    sel_dec_d  = 16'h0001 << idx_d;
    timeout_d  = (timer_q == 8'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b0;
      timer_q  <= '0;
      b_addr_q <= '0;
      b_data_q <= '0;
      b_we_q   <= 1'b0;
      b_sel_q  <= '0;
      i_data_q <= '0;
      i_ack_q  <= 1'b0;
      i_err_q  <= 1'b0;
      d_data_q <= '0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            last_q <= pick_d_d;
            if (dec_ok_d) begin
              b_addr_q <= req_addr_d;
              b_data_q <= pick_d_d ? d_data_i : '0;
              b_we_q   <= pick_d_d & d_we_i;
              b_sel_q  <= sel_dec_d;
              timer_q  <= '0;
              state_q  <= BUSY;
            end else begin
              // decode error: no bus cycle, respond with err directly
              i_err_q <= ~pick_d_d;
              d_err_q <= pick_d_d;
              state_q <= RESP;
            end
          end
        end
        BUSY: begin
          timer_q <= timer_q + 8'd1;
          // ack takes priority over a coincident timeout
          if (b_ack_i || timeout_d) begin
            if (b_ack_i) begin
              if (last_q) begin
                d_ack_q  <= 1'b1;
                d_data_q <= b_data_i;
              end else begin
                i_ack_q  <= 1'b1;
                i_data_q <= b_data_i;
              end
            end else begin
              i_err_q <= ~last_q;
              d_err_q <= last_q;
            end
            b_addr_q <= '0;
            b_data_q <= '0;
            b_we_q   <= 1'b0;
            b_sel_q  <= '0;
            state_q  <= RESP;
          end
        end
        RESP: begin
          i_data_q <= '0;
          i_ack_q  <= 1'b0;
          i_err_q  <= 1'b0;
          d_data_q <= '0;
          d_ack_q  <= 1'b0;
          d_err_q  <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_data_o   = i_data_q;
  assign i_ack_o    = i_ack_q;
  assign i_err_o    = i_err_q;
  assign d_data_o   = d_data_q;
  assign d_ack_o    = d_ack_q;
  assign d_err_o    = d_err_q;
  assign b_addr_o   = b_addr_q;
  assign b_data_o   = b_data_q;
  assign b_we_o     = b_we_q;
  assign b_select_o = b_sel_q;
  assign grant_o    = last_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (TIMEOUT_CYCLES=4, NUM_SLAVES=8).
// Inputs change and outputs are checked on the falling clock edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_data_o;
  logic        i_ack_o;
  logic        i_err_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_data_i;
  logic [31:0] d_data_o;
  logic        d_ack_o;
  logic        d_err_o;
  logic [31:0] b_addr_o;
  logic [31:0] b_data_o;
  logic        b_we_o;
  logic [15:0] b_select_o;
  logic [31:0] b_data_i;
  logic        b_ack_i;
  logic        grant_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT_CYCLES(4), .NUM_SLAVES(8)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_data_o(i_data_o),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_data_i(d_data_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .d_err_o(d_err_o),
    .b_addr_o(b_addr_o), .b_data_o(b_data_o), .b_we_o(b_we_o),
    .b_select_o(b_select_o), .b_data_i(b_data_i), .b_ack_i(b_ack_i),
    .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; i_req_i = 0; i_addr_i = '0; d_req_i = 0; d_we_i = 0;
    d_addr_i = '0; d_data_i = '0; b_data_i = '0; b_ack_i = 0;

    // reset state
    step();
    chk("rst_sel", 32'(b_select_o), 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_acks", {28'd0, i_ack_o, i_err_o, d_ack_o, d_err_o}, 0);
    chk("rst_baddr", b_addr_o, 0);
    rst = 1'b1;
    step(); step();
    chk("idle_sel", 32'(b_select_o), 0);

    // ibus read, slave acks on the second busy cycle
    i_req_i = 1; i_addr_i = 32'h1000_0040;
    step();
    chk("ird_sel", 32'(b_select_o), 32'h0002);
    chk("ird_addr", b_addr_o, 32'h1000_0040);
    chk("ird_we", 32'(b_we_o), 0);
    chk("ird_grant", 32'(grant_o), 0);
    step();
    chk("ird_sel_hold", 32'(b_select_o), 32'h0002);
    b_ack_i = 1; b_data_i = 32'hDEAD_BEEF;
    step();
    chk("ird_ack", 32'(i_ack_o), 1);
    chk("ird_data", i_data_o, 32'hDEAD_BEEF);
    chk("ird_dack", 32'(d_ack_o), 0);
    chk("ird_ierr", 32'(i_err_o), 0);
    chk("ird_sel_off", 32'(b_select_o), 0);
    i_req_i = 0; b_ack_i = 0; b_data_i = '0;
    step();
    chk("ird_ack_end", 32'(i_ack_o), 0);
    chk("ird_data_end", i_data_o, 0);

    // dbus write
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h7000_0000; d_data_i = 32'h0000_00A5;
    step();
    chk("dwr_sel", 32'(b_select_o), 32'h0080);
    chk("dwr_we", 32'(b_we_o), 1);
    chk("dwr_data", b_data_o, 32'h0000_00A5);
    chk("dwr_grant", 32'(grant_o), 1);
    step();
    chk("dwr_sel_hold", 32'(b_select_o), 32'h0080);
    chk("dwr_data_hold", b_data_o, 32'h0000_00A5);
    b_ack_i = 1;
    step();
    chk("dwr_ack", 32'(d_ack_o), 1);
    chk("dwr_iack", 32'(i_ack_o), 0);
    chk("dwr_sel_off", 32'(b_select_o), 0);
    chk("dwr_we_off", 32'(b_we_o), 0);
    d_req_i = 0; d_we_i = 0; b_ack_i = 0;
    step();
    chk("dwr_ack_end", 32'(d_ack_o), 0);

    // decode error: region 8 with NUM_SLAVES=8
    d_req_i = 1; d_addr_i = 32'h8000_0000;
    step();
    chk("dec_sel", 32'(b_select_o), 0);
    chk("dec_err", 32'(d_err_o), 1);
    chk("dec_ack", 32'(d_ack_o), 0);
    chk("dec_ierr", 32'(i_err_o), 0);
    d_req_i = 0;
    step();
    chk("dec_err_end", 32'(d_err_o), 0);
    chk("dec_sel_end", 32'(b_select_o), 0);

    // timeout: select held exactly 4 cycles, then ibus err
    i_req_i = 1; i_addr_i = 32'h0000_0000;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_sel%0d", k), 32'(b_select_o), 32'h0001);
      step();
    end
    chk("to_sel_off", 32'(b_select_o), 0);
    chk("to_err", 32'(i_err_o), 1);
    chk("to_ack", 32'(i_ack_o), 0);
    i_req_i = 0;
    step();
    chk("to_err_end", 32'(i_err_o), 0);

    // ack on the final busy cycle beats the timeout
    i_req_i = 1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tack_sel%0d", k), 32'(b_select_o), 32'h0001);
      step();
    end
    chk("tack_sel3", 32'(b_select_o), 32'h0001);
    b_ack_i = 1; b_data_i = 32'h1234_5678;
    step();
    chk("tack_ack", 32'(i_ack_o), 1);
    chk("tack_err", 32'(i_err_o), 0);
    chk("tack_data", i_data_o, 32'h1234_5678);
    i_req_i = 0; b_ack_i = 0; b_data_i = '0;
    step();

    // contention from reset: dbus, ibus, dbus, ibus
    rst = 0;
    i_req_i = 1; i_addr_i = 32'h1000_0000;
    d_req_i = 1; d_addr_i = 32'h2000_0000; d_we_i = 0;
    b_ack_i = 1;
    step();
    chk("cont_rst_grant", 32'(grant_o), 0);
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      b_data_i = 32'hC0DE_0000 + 32'(k);
      step();
      chk($sformatf("cont_grant%0d", k), 32'(grant_o), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("cont_sel%0d", k), 32'(b_select_o), (k % 2 == 0) ? 32'h0004 : 32'h0002);
      step();
      chk($sformatf("cont_dack%0d", k), 32'(d_ack_o), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("cont_iack%0d", k), 32'(i_ack_o), (k % 2 == 0) ? 0 : 1);
      chk($sformatf("cont_data%0d", k), (k % 2 == 0) ? d_data_o : i_data_o,
          32'hC0DE_0000 + 32'(k));
      step();
      chk($sformatf("cont_idle%0d", k), {30'd0, i_ack_o, d_ack_o}, 0);
    end
    i_req_i = 0; d_req_i = 0; b_ack_i = 0; b_data_i = '0;
    step();

    // reset mid-BUSY aborts silently
    d_req_i = 1; d_addr_i = 32'h3000_0000;
    step();
    chk("mrst_busy_sel", 32'(b_select_o), 32'h0008);
    chk("mrst_busy_grant", 32'(grant_o), 1);
    d_req_i = 0;
    #1 rst = 0;
    #1;
    chk("mrst_sel", 32'(b_select_o), 0);
    chk("mrst_grant", 32'(grant_o), 0);
    chk("mrst_resp", {28'd0, i_ack_o, i_err_o, d_ack_o, d_err_o}, 0);
    step();
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mrst_idle%0d", k),
          {12'd0, b_select_o, i_ack_o, i_err_o, d_ack_o, d_err_o}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
